// File: rtl/adder_serial_pkg.sv
// adder_serial_pkg: shared FSM state type and step-sizing helpers for the serial adder
package adder_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_steps(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int step_w(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// adder_chunk: combinational CHUNK-bit adder exposing carry into and out of its MSB
module adder_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] full;

  // carry into the MSB is recovered from the MSB sum bit and the MSB operand bits
  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    s    = full[CHUNK-1:0];
    cout = full[CHUNK];
    cmsb = full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
  end

endmodule

// File: rtl/adder_serial.sv
// adder_serial: digit-serial WIDTH-bit adder, CHUNK bits per clock; ADDER_SERIAL_SUB_EN adds a subtract port
module adder_serial
  import adder_serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
`ifdef ADDER_SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int STEPS = num_steps(WIDTH, CHUNK);
  localparam int SW    = step_w(STEPS);

  if (CHUNK < 1 || CHUNK > WIDTH || WIDTH % CHUNK != 0) begin : g_bad
    $error("adder_serial: CHUNK must divide WIDTH and lie in 1..WIDTH");
  end

  state_t                   state_q, state_d;
  logic [WIDTH-1:0]         a_r, b_r, sum_r, b_in;
  logic                     carry_r, cout_r, ovf_r, c_in, cc, cm, last;
  logic [SW-1:0]            step;
  logic [CHUNK-1:0]         cs;
  logic [WIDTH+CHUNK-1:0]   cat;

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_r[CHUNK-1:0]),
    .b    (b_r[CHUNK-1:0]),
    .cin  (carry_r),
    .s    (cs),
    .cout (cc),
    .cmsb (cm)
  );

  // operand conditioning at accept time and the sum shift-in path
  always_comb begin
`ifdef ADDER_SERIAL_SUB_EN
    b_in = sub ? ~b : b;
    c_in = sub ? ~carry_in : carry_in;
`else
    b_in = b;
    c_in = carry_in;
`endif
    cat  = {cs, sum_r};
    last = step == SW'(STEPS - 1);
  end

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;

  // next state; a simultaneous in_valid in DONE is left for IDLE to take
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && in_valid)  state_d = RUN;
    if (state_q == RUN && last)       state_d = DONE;
    if (state_q == DONE && out_ready) state_d = IDLE;
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
  end

  // datapath: latch on accept, then one chunk per RUN cycle, LS chunk first
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      step    <= '0;
    end else if (state_q == IDLE && in_valid) begin
      a_r     <= a;
      b_r     <= b_in;
      carry_r <= c_in;
      step    <= '0;
    end else if (state_q == RUN) begin
      a_r     <= a_r >> CHUNK;
      b_r     <= b_r >> CHUNK;
      sum_r   <= cat[WIDTH+CHUNK-1:CHUNK];
      carry_r <= cc;
      step    <= step + 1'b1;
      if (last) begin
        cout_r <= cc;
        ovf_r  <= cc ^ cm;
      end
    end

  assign sum       = sum_r;
  assign carry_out = cout_r;
  assign overflow  = ovf_r;

endmodule
